// File: rtl/regheap_pkg.sv
// Shared definitions for the register heap: default geometry and word type.
package regheap_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int NUM_REGS   = 16;

    typedef logic [DATA_W_DEF-1:0] reg_word_t;

endpackage

// File: rtl/regheap_bank.sv
// One bank of NREG x DATA_W registers.
// - Single-entry write port.
// - Full-bank load path.
// - Synchronous reset.
// - Two combinational read ports.
// - The whole bank is also exported so the other bank can copy it.
// Priority: reset > full load > single write.
module regheap_bank
    import regheap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            waddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic                         load_i,
    input  logic [NREG-1:0][DATA_W-1:0]  load_data_i,
    input  logic [ADDR_W-1:0]            raddr1_i,
    input  logic [ADDR_W-1:0]            raddr2_i,
    output logic [DATA_W-1:0]            rdata1_o,
    output logic [DATA_W-1:0]            rdata2_o,
    output logic [NREG-1:0][DATA_W-1:0]  regs_o
);

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;

    // Next bank contents: a full load replaces everything, otherwise a single write.
    always_comb begin
        regs_d = regs_q;
        if (load_i) begin
            regs_d = load_data_i;
        end else if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Bank storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];
    assign regs_o   = regs_q;

endmodule

// File: rtl/register_heap.sv
// Register heap: a working bank with a shadow bank.
// - Save copies the working bank (including a same-cycle write) into the shadow bank.
// - Restore copies the shadow bank back; it discards a same-cycle write.
// - If save and restore are both asserted, restore wins.
// Optional feature: define REGHEAP_BYPASS_EN to forward wdata_i to a read port
// whose index matches an in-flight write.
module register_heap
    import regheap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] rdreg1_i,
    input  logic [ADDR_W-1:0] rdreg2_i,
    input  logic              regwrite_i,
    input  logic [ADDR_W-1:0] wrreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              save_i,
    input  logic              restore_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int NREG = 2**ADDR_W;

    logic                        work_we;
    logic                        shad_load;
    logic [NREG-1:0][DATA_W-1:0] work_regs;
    logic [NREG-1:0][DATA_W-1:0] shad_regs;
    logic [NREG-1:0][DATA_W-1:0] save_data;
    logic [DATA_W-1:0]           work_rd1, work_rd2;
    logic [DATA_W-1:0]           shad_rd1_unused, shad_rd2_unused;

    // Restore takes precedence over both a write and a save.
    always_comb begin
        work_we   = regwrite_i & ~restore_i;
        shad_load = save_i & ~restore_i;
    end

    // The shadow bank captures the post-edge working contents, so it sees a same-cycle write.
    always_comb begin
        save_data = work_regs;
        if (regwrite_i) begin
            save_data[wrreg_i] = wdata_i;
        end
    end

    regheap_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_work (
        .clk         (CLK),
        .rst         (RST),
        .we_i        (work_we),
        .waddr_i     (wrreg_i),
        .wdata_i     (wdata_i),
        .load_i      (restore_i),
        .load_data_i (shad_regs),
        .raddr1_i    (rdreg1_i),
        .raddr2_i    (rdreg2_i),
        .rdata1_o    (work_rd1),
        .rdata2_o    (work_rd2),
        .regs_o      (work_regs)
    );

    regheap_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_shadow (
        .clk         (CLK),
        .rst         (RST),
        .we_i        (1'b0),
        .waddr_i     (wrreg_i),
        .wdata_i     (wdata_i),
        .load_i      (shad_load),
        .load_data_i (save_data),
        .raddr1_i    (rdreg1_i),
        .raddr2_i    (rdreg2_i),
        .rdata1_o    (shad_rd1_unused),
        .rdata2_o    (shad_rd2_unused),
        .regs_o      (shad_regs)
    );

`ifdef REGHEAP_BYPASS_EN
    logic byp_ok;

    // Forward an in-flight write to any read port addressing the same register.
    always_comb begin
        byp_ok   = regwrite_i & ~restore_i & ~RST;
        rdata1_o = work_rd1;
        rdata2_o = work_rd2;
        if (byp_ok && (rdreg1_i == wrreg_i)) rdata1_o = wdata_i;
        if (byp_ok && (rdreg2_i == wrreg_i)) rdata2_o = wdata_i;
    end
`else
    // Reads always show the stored working value.
    always_comb begin
        rdata1_o = work_rd1;
        rdata2_o = work_rd2;
    end
`endif

endmodule

// File: tb/tb_register_heap.sv
// Scoreboard bench for register_heap: a behavioural model of both banks
// produces the expected read data, which is queued at stimulus time and
// popped when the read ports are sampled.
module tb_register_heap;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] rdreg1_i, rdreg2_i, wrreg_i;
    logic          regwrite_i, save_i, restore_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata1_o, rdata2_o;

    register_heap #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rdreg1_i   (rdreg1_i),
        .rdreg2_i   (rdreg2_i),
        .regwrite_i (regwrite_i),
        .wrreg_i    (wrreg_i),
        .wdata_i    (wdata_i),
        .save_i     (save_i),
        .restore_i  (restore_i),
        .rdata1_o   (rdata1_o),
        .rdata2_o   (rdata2_o)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] m_work [NR];
    logic [DW-1:0] m_shad [NR];
    logic [DW-1:0] exp_q  [$];
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Pop both expected values and compare against the two read ports.
    task automatic sample(input string tag);
        logic [DW-1:0] e1, e2;
        #1;
        if (exp_q.size() < 2) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: scoreboard underflow", tag);
        end else begin
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            chk({tag, ".p1"}, rdata1_o, e1);
            chk({tag, ".p2"}, rdata2_o, e2);
        end
    endtask

    // Idle read of two registers.
    task automatic rd(input string tag, input int a1, input int a2);
        @(negedge CLK);
        RST        = 1'b0;
        regwrite_i = 1'b0;
        save_i     = 1'b0;
        restore_i  = 1'b0;
        rdreg1_i   = AW'(a1);
        rdreg2_i   = AW'(a2);
        exp_q.push_back(m_work[a1]);
        exp_q.push_back(m_work[a2]);
        sample(tag);
    endtask

    // One clocked operation, then the model is advanced. While a write is
    // in flight, port 1 reads the target register and port 2 a neighbour.
    task automatic step(input logic r, input logic we, input int wa, input logic [DW-1:0] wd,
                        input logic sv, input logic rs);
        logic [DW-1:0] e1;
        @(negedge CLK);
        RST        = r;
        regwrite_i = we;
        wrreg_i    = AW'(wa);
        wdata_i    = wd;
        save_i     = sv;
        restore_i  = rs;
        rdreg1_i   = AW'(wa);
        rdreg2_i   = AW'(wa ^ 1);
        e1 = m_work[wa];
`ifdef REGHEAP_BYPASS_EN
        if (we && !rs && !r) e1 = wd;
`endif
        exp_q.push_back(e1);
        exp_q.push_back(m_work[wa ^ 1]);
        sample("inflight");
        @(posedge CLK);
        if (r) begin
            for (int k = 0; k < NR; k++) begin
                m_work[k] = '0;
                m_shad[k] = '0;
            end
        end else if (rs) begin
            for (int k = 0; k < NR; k++) m_work[k] = m_shad[k];
        end else begin
            if (we) m_work[wa] = wd;
            if (sv) for (int k = 0; k < NR; k++) m_shad[k] = m_work[k];
        end
    endtask

    initial begin
        RST = 1'b1; regwrite_i = 0; save_i = 0; restore_i = 0;
        wrreg_i = '0; wdata_i = '0; rdreg1_i = '0; rdreg2_i = '0;
        for (int k = 0; k < NR; k++) begin
            m_work[k] = 16'hxxxx;
            m_shad[k] = 16'hxxxx;
        end
        step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);

        // Reset state, including registers 8 and 9.
        rd("rst_8_9", 8, 9);
        for (int k = 0; k < NR; k += 2) rd("rst_all", k, k + 1);

        // Basic writes, then a pattern across the bank.
        step(0, 1, 8, 16'h1234, 0, 0);
        step(0, 1, 9, 16'hBEEF, 0, 0);
        rd("wr_8_9", 8, 9);
        rd("same_idx", 8, 8);
        for (int k = 0; k < NR; k++) if (k != 8 && k != 9) step(0, 1, k, DW'(16'h0101 * k + 16'h00A0), 0, 0);
        for (int k = 0; k < NR; k += 2) rd("pattern", k, k + 1);

        // Save, overwrite, restore.
        step(0, 0, 0, '0, 1, 0);
        step(0, 1, 8, 16'h5555, 0, 0);
        step(0, 1, 3, 16'h7777, 0, 0);
        rd("overwrite", 8, 3);
        step(0, 0, 0, '0, 0, 1);
        rd("restore", 8, 3);

        // Save and restore together: restore wins and the shadow bank holds.
        step(0, 1, 8, 16'h1111, 1, 0);
        step(0, 1, 8, 16'h2222, 0, 0);
        step(0, 0, 0, '0, 1, 1);
        rd("sv_rs_work", 8, 9);
        step(0, 1, 8, 16'h3333, 0, 0);
        step(0, 0, 0, '0, 0, 1);
        rd("sv_rs_shad", 8, 9);

        // A write in the restore cycle is discarded.
        step(0, 1, 5, 16'hAAAA, 0, 1);
        rd("wr_rs", 5, 4);

        // Save captures a same-cycle write.
        step(0, 1, 7, 16'h4242, 1, 0);
        step(0, 1, 7, 16'h0000, 0, 0);
        step(0, 0, 0, '0, 0, 1);
        rd("sv_wr", 7, 6);

        // Random mix of operations.
        for (int i = 0; i < 60; i++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            step(0, op < 7, int'($urandom_range(0, NR - 1)), DW'($urandom),
                 op == 7 || op == 9, op >= 8);
            rd("rand", int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)));
        end

        // Reset with a write pending, then restore still yields zero.
        step(0, 1, 2, 16'h9999, 1, 0);
        step(1, 1, 2, 16'hFFFF, 1, 0);
        for (int k = 0; k < NR; k += 2) rd("rst_wr", k, k + 1);
        step(0, 0, 0, '0, 0, 1);
        for (int k = 0; k < NR; k += 2) rd("rst_rs", k, k + 1);

        if (exp_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/register_heap.md
REGISTER_HEAP -- requirements
Module: register_heap

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving the register data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 4, giving the register index width; register count = 2**ADDR_W (16).
REQ-003 The module SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port rdreg1_i, input, ADDR_W bits: read port 1 register index.
REQ-006 The module SHALL have port rdreg2_i, input, ADDR_W bits: read port 2 register index.
REQ-007 The module SHALL have port regwrite_i, input, 1 bit: write enable for the working bank.
REQ-008 The module SHALL have port wrreg_i, input, ADDR_W bits: write register index.
REQ-009 The module SHALL have port wdata_i, input, DATA_W bits: write data.
REQ-010 The module SHALL have port save_i, input, 1 bit: copy the working bank into the shadow bank.
REQ-011 The module SHALL have port restore_i, input, 1 bit: copy the shadow bank into the working bank.
REQ-012 The module SHALL have port rdata1_o, output, DATA_W bits: read port 1 data.
REQ-013 The module SHALL have port rdata2_o, output, DATA_W bits: read port 2 data.

Function
REQ-014 Storage SHALL be two banks (working, shadow) of 16 x DATA_W registers; no register is hardwired to a constant.
REQ-015 Reads SHALL be combinational, zero latency: rdataN_o = working[rdregN_i]; both ports are independent and may address the same register.
REQ-016 With regwrite_i=1 and restore_i=0, working[wrreg_i] SHALL take wdata_i at the rising edge; other registers hold.
REQ-017 With save_i=1 and restore_i=0, every shadow[k] SHALL take the post-edge working[k] value, including a same-cycle write.
REQ-018 With restore_i=1, every working[k] SHALL take shadow[k] at the edge; a same-cycle regwrite_i is discarded.
REQ-019 With save_i=1 and restore_i=1, restore SHALL win and the shadow bank SHALL be unchanged.
REQ-020 With regwrite_i, save_i and restore_i all 0, both banks SHALL hold.
REQ-021 Writes, saves and restores SHALL become visible on the read ports in the cycle after the edge (subject to REQ-025).

Reset
REQ-022 With RST=1 at a rising edge, all working and shadow registers SHALL become 0; RST overrides regwrite_i, save_i and restore_i.
REQ-023 The outputs SHALL read 0 for every index in the cycle after reset; no asynchronous reset path exists.

Configuration
REQ-024 Macro REGHEAP_BYPASS_EN SHALL select write-through read bypass.
REQ-025 With REGHEAP_BYPASS_EN defined, if regwrite_i=1, restore_i=0, RST=0 and rdregN_i==wrreg_i, rdataN_o SHALL equal wdata_i combinationally; all other cases follow REQ-015.
REQ-026 Without REGHEAP_BYPASS_EN, rdataN_o SHALL always follow REQ-015, showing the stored value.

Structure
REQ-027 A shared package regheap_pkg SHALL hold DATA_W/ADDR_W defaults, NUM_REGS=16 and a reg_word_t typedef.
REQ-028 One sub-module, regheap_bank (16 x DATA_W registers with write port, reset and two combinational read ports), SHALL be instantiated twice.
REQ-029 The shadow instance of regheap_bank SHALL use its full-bank load path for save.

Verification
REQ-030 Reset, then read indices 8 and 9 -> rdata1_o=0x0000, rdata2_o=0x0000.
REQ-031 Write 0x1234 to reg 8 and 0xBEEF to reg 9, then read rdreg1_i=8, rdreg2_i=9 -> 0x1234 / 0xBEEF next cycle; with bypass, during the write cycle the read shows wdata_i.
REQ-032 Save with reg 8=0x1234, overwrite reg 8 with 0x5555, then restore -> reg 8 reads 0x1234; overwritten reg 3 also reverts to its saved value.
REQ-033 Assert save_i and restore_i together with shadow reg 8=0x1111 and working reg 8=0x2222 -> reg 8 reads 0x1111 and shadow remains 0x1111.
REQ-034 Assert regwrite_i (reg 5, 0xAAAA) with restore_i -> reg 5 reads its shadow value, not 0xAAAA.
REQ-035 Assert RST with regwrite_i=1 (reg 2, 0xFFFF) after loading data -> all registers read 0, and a subsequent restore yields 0.
